// File: rtl/odd_parity_rx_if.sv
// Bit-level line and word-level result bundle for odd_parity_rx.
// master = line/consumer side, slave = the receiver.
interface odd_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [7:0]        err_count;

  modport master (
    output bit_in, bit_valid,
    input  data_out, data_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  bit_in, bit_valid,
    output data_out, data_valid, parity_err, frame_err, busy, err_count
  );
endinterface

// File: rtl/odd_parity_rx.sv
// Serial odd-parity frame receiver: start, DATA_W data bits LSB-first, odd parity, stop.
// Define ODD_PARITY_RX_ERR_COUNT_EN to build the saturating error-frame counter.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a sampled 0 (start bit)
// ST_DATA   | shifting in DATA_W data bits
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit, results registered out
module odd_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  odd_parity_rx_if.slave rx
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;
  localparam int         CNT_W     = $clog2(DATA_W + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              pe_q, pe_d;
  logic              fe_q, fe_d;
  logic              frame_done;

  assign frame_done = rx.bit_valid && (state_q == ST_STOP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    if (rx.bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx.bit_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d = {rx.bit_in, shift_q[DATA_W-1:1]};
          par_d   = par_q ^ rx.bit_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = par_q ^ rx.bit_in;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = shift_q;
          dv_d    = 1'b1;
          pe_d    = ~par_q;
          fe_d    = ~rx.bit_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = dv_q;
  assign rx.parity_err = pe_q;
  assign rx.frame_err  = fe_q;
  assign rx.busy       = (state_q != ST_IDLE);

`ifdef ODD_PARITY_RX_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counted at the stop-sampling edge so the new value lines up with data_valid.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_done && (!par_q || !rx.bit_in) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign rx.err_count = err_cnt_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
  assign rx.err_count      = 8'h00;
`endif
endmodule

// File: tb/tb_odd_parity_rx.sv
// Randomized self-checking bench for odd_parity_rx against a frame-level reference model.
module tb_odd_parity_rx;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          fe;
    logic [7:0]    ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   gap_mode = 0;
  int   ec_model = 0;
  exp_t exp_q[$];

  odd_parity_rx_if #(.DATA_W(DW)) rx_if ();

  odd_parity_rx #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; bit_valid idles with junk on bit_in to prove holding.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      rx_if.bit_valid = 1'b0;
      rx_if.bit_in    = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic strobe(input logic b, input int kind);
    rx_if.bit_in    = b;
    rx_if.bit_valid = 1'b1;
    @(negedge clk);
    if (kind == 1) chk("busy_after_start", 32'(rx_if.busy), 32'd1);
    if (kind == 2) begin
      chk("dv_latency", 32'(rx_if.data_valid), 32'd1);
      chk("busy_after_stop", 32'(rx_if.busy), 32'd0);
    end
    rx_if.bit_valid = 1'b0;
    case (gap_mode)
      1:       idle_gap(1);
      2:       idle_gap($urandom_range(0, 2));
      default: ;
    endcase
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    exp_t e;
    logic pe;
    pe = (($countones(d) + int'(par)) % 2) == 0;
    e.data = d;
    e.pe   = pe;
    e.fe   = ~stop;
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
    if ((pe || !stop) && ec_model < 255) ec_model++;
`endif
    e.ec = 8'(ec_model);
    exp_q.push_back(e);
    strobe(1'b0, 1);
    for (int i = 0; i < DW; i++) strobe(d[i], 0);
    strobe(par, 0);
    strobe(stop, 2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rx_if.data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dv", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(rx_if.data_out), 32'(e.data));
          chk("parity_err", 32'(rx_if.parity_err), 32'(e.pe));
          chk("frame_err", 32'(rx_if.frame_err), 32'(e.fe));
          chk("err_count", 32'(rx_if.err_count), 32'(e.ec));
        end
      end else if (rx_if.parity_err || rx_if.frame_err) begin
        chk("flags_without_dv", {30'd0, rx_if.parity_err, rx_if.frame_err}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(rx_if.data_out), 32'd0);
    chk({tag, "_dv"}, 32'(rx_if.data_valid), 32'd0);
    chk({tag, "_pe"}, 32'(rx_if.parity_err), 32'd0);
    chk({tag, "_fe"}, 32'(rx_if.frame_err), 32'd0);
    chk({tag, "_busy"}, 32'(rx_if.busy), 32'd0);
    chk({tag, "_err_count"}, 32'(rx_if.err_count), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          par, stop;
    rx_if.bit_in    = 1'b1;
    rx_if.bit_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;

    gap_mode = 0;
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    send_frame(8'h00, 1'b1, 1'b0);
    idle_gap(2);

    gap_mode = 1;
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    gap_mode = 0;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_gap(3);

    // Reset after four data bits, with a strobe present to prove reset wins.
    strobe(1'b0, 1);
    for (int i = 0; i < 4; i++) strobe(1'($urandom), 0);
    rst = 1'b1;
    rx_if.bit_valid = 1'b1;
    rx_if.bit_in    = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    rx_if.bit_valid = 1'b0;
    ec_model = 0;
    exp_q.delete();
    idle_gap(1);
    send_frame(8'h7E, 1'b1, 1'b1);

    for (int n = 0; n < 60; n++) begin
      gap_mode = int'($urandom_range(0, 2));
      d    = DW'($urandom);
      par  = ($urandom_range(0, 3) == 0) ? (^d) : ~(^d);
      stop = ($urandom_range(0, 4) != 0);
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) strobe(1'b1, 0);
      send_frame(d, par, stop);
    end

    gap_mode = 0;
    for (int n = 0; n < 300; n++) begin
      d = DW'($urandom);
      send_frame(d, ^d, 1'b1);
    end
    idle_gap(3);
`ifdef ODD_PARITY_RX_ERR_COUNT_EN
    chk("err_count_saturated", 32'(rx_if.err_count), 32'd255);
`else
    chk("err_count_tied", 32'(rx_if.err_count), 32'd0);
`endif
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
